// File: rtl/fsa_root_node.sv
// Root arbiter of the Fair-Switch-Arbiter tree: same-cycle round-robin ack to one leaf,
// plus the ARB -> UPD -> SETTLE sequence that issues the lock-clear update pulse.
module fsa_root_node #(
    parameter int                  NUM_LEAF = 4,
    parameter logic [NUM_LEAF-1:0] INIT_PTR = 1,
    parameter int                  CNT_W    = 8,
    localparam int                 IDX_W    = (NUM_LEAF > 1) ? $clog2(NUM_LEAF) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_LEAF-1:0] leaf_req,
    input  logic [NUM_LEAF-1:0] leaf_pend,
    input  logic                res_ready,
    output logic [NUM_LEAF-1:0] ack,
    output logic                update,
    output logic                grant_valid,
    output logic [IDX_W-1:0]    grant_leaf,
    output logic [CNT_W-1:0]    round_cnt,
    output logic                busy
);

    typedef enum logic [1:0] {ARB, UPD, SETTLE} state_e;

    state_e              state_q, state_d;
    logic [NUM_LEAF-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]    round_cnt_q, round_cnt_d;
    logic                update_q, update_d;

    logic [NUM_LEAF-1:0] ptr_eff;
    logic                found;
    logic [IDX_W-1:0]    win_idx;
    logic                grant_en;

    // A corrupted (non one-hot) pointer falls back to the reset priority order.
    always_comb begin
        ptr_eff = ptr_q;
        if (ptr_q == '0 || (ptr_q & (ptr_q - NUM_LEAF'(1))) != '0)
            ptr_eff = INIT_PTR;
    end

    // Search k-1, k-2, ... wrapping back to k; the nested loops keep every index constant.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_LEAF; k++) begin
            if (ptr_eff[k]) begin
                for (int i = 1; i <= NUM_LEAF; i++) begin
                    if (!found && leaf_req[(k + NUM_LEAF - i) % NUM_LEAF]) begin
                        found   = 1'b1;
                        win_idx = IDX_W'((k + NUM_LEAF - i) % NUM_LEAF);
                    end
                end
            end
        end
    end

    assign grant_en = !rst && (state_q == ARB) && res_ready && found;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB;
            ptr_q       <= INIT_PTR;
            round_cnt_q <= '0;
            update_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            round_cnt_q <= round_cnt_d;
            update_q    <= update_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        round_cnt_d = round_cnt_q;
        case (state_q)
            ARB: begin
                if (grant_en) begin
                    ptr_d = '0;
                    ptr_d[win_idx] = 1'b1;
                end else if (!(|leaf_req) && (|leaf_pend)) begin
                    state_d = UPD;
                end
            end
            UPD: begin
                round_cnt_d = round_cnt_q + CNT_W'(1);
                state_d     = SETTLE;
            end
            SETTLE:  state_d = ARB;
            default: state_d = ARB;
        endcase
        update_d = (state_d == UPD);
    end

    // Output logic
    always_comb begin
        ack         = '0;
        grant_valid = grant_en;
        grant_leaf  = '0;
        if (grant_en) begin
            ack[win_idx] = 1'b1;
            grant_leaf   = win_idx;
        end
    end

    assign update    = update_q;
    assign round_cnt = round_cnt_q;
    assign busy      = (state_q != ARB) || (|leaf_pend);

endmodule
